valve_sequencer: RTL and testbench

// Downstream actuator stage of the two-zone irrigation controller. Consumes the per-outlet

---
 rtl/valve_sequencer_if.sv | 22 ++
 rtl/valve_sequencer.sv | 164 ++++++++++++++++
 tb/tb_valve_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/valve_sequencer_if.sv
// rtl/valve_sequencer_if.sv - request/status bundle between zone logic and the valve sequencer
interface valve_sequencer_if;
   logic [1:0] r1;
   logic [1:0] r2;
   logic [1:0] e;
   logic       alarm_clr;
   logic [3:0] valve;
   logic       pump;
   logic       alarm;
   logic       busy;

   // The zone side drives requests and acknowledges; the sequencer drives the actuators.
   modport master (
      output r1, r2, e, alarm_clr,
      input  valve, pump, alarm, busy
   );

   modport slave (
      input  r1, r2, e, alarm_clr,
      output valve, pump, alarm, busy
   );
endinterface

// File: rtl/valve_sequencer.sv
// rtl/valve_sequencer.sv - pump lead, staggered valve opening, min/max open time and fault latch
module valve_sequencer #(
   parameter int CNT_W     = 8,
   parameter int PUMP_LEAD = 4,
   parameter int STAGGER   = 3,
   parameter int MIN_ON    = 8,
   parameter int MAX_ON    = 64
) (
   input  logic             clk,
   input  logic             reset,
   valve_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PUMP_START, RUN, FAULT} state_t;

   // Counters hold "edges already seen", so each limit is compared against its value minus one.
   localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(PUMP_LEAD - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
   localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_ON - 1);

   state_t           state, state_nx;
   logic [3:0]       valve_q, valve_nx;
   logic [3:0]       lockout, lock_nx;
   logic             pump_q, alarm_q, busy_q;
   logic             alarm_nx, active_nx;
   logic [CNT_W-1:0] lead_cnt, lead_nx;
   logic [CNT_W-1:0] stag_cnt, stag_nx;
   logic [CNT_W-1:0] on_cnt [4];
   logic [CNT_W-1:0] on_nx  [4];
   logic [3:0]       req, eff_req, cand, open_mask, forced;
   logic             fault_in;

   assign req      = {bus.r2, bus.r1};
   assign eff_req  = req & ~lockout;
   assign fault_in = (bus.e == 2'b00);

   assign bus.valve = valve_q;
   assign bus.pump  = pump_q;
   assign bus.alarm = alarm_q;
   assign bus.busy  = busy_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [3:0] lowest(input logic [3:0] v);
      return v & (~v + 4'd1);
   endfunction

   // Next-state, valve, timer and lockout decisions; fault overrides everything at the end.
   always_comb begin
      state_nx  = state;
      valve_nx  = valve_q;
      alarm_nx  = alarm_q;
      lead_nx   = lead_cnt;
      stag_nx   = stag_cnt;
      on_nx     = on_cnt;
      cand      = 4'b0;
      open_mask = 4'b0;
      forced    = 4'b0;

      case (state)
         IDLE: begin
            valve_nx = 4'b0;
            lead_nx  = '0;
            stag_nx  = '0;
            if (eff_req != 4'b0) state_nx = PUMP_START;
         end
         PUMP_START: begin
            valve_nx = 4'b0;
            if (eff_req == 4'b0) begin
               state_nx = IDLE;
               lead_nx  = '0;
            end else if (lead_cnt >= LEAD_LAST) begin
               state_nx  = RUN;
               open_mask = lowest(eff_req);
               stag_nx   = '0;
               lead_nx   = '0;
            end else begin
               lead_nx = sat_inc(lead_cnt);
            end
         end
         RUN: begin
            // Forced close at MAX_ON outranks a release close; both bypass the stagger.
            for (int i = 0; i < 4; i++) begin
               if (valve_q[i]) begin
                  if (on_cnt[i] >= MAX_LAST) begin
                     valve_nx[i] = 1'b0;
                     forced[i]   = 1'b1;
                     on_nx[i]    = '0;
                  end else if (!req[i] && on_cnt[i] >= MIN_LAST) begin
                     valve_nx[i] = 1'b0;
                     on_nx[i]    = '0;
                  end else begin
                     on_nx[i] = sat_inc(on_cnt[i]);
                  end
               end
            end
            cand = eff_req & ~valve_q;
            if (stag_cnt >= STAG_LAST && cand != 4'b0) begin
               open_mask = lowest(cand);
               stag_nx   = '0;
            end else begin
               stag_nx = sat_inc(stag_cnt);
            end
            if ((valve_nx | open_mask) == 4'b0 && eff_req == 4'b0) state_nx = IDLE;
         end
         FAULT: begin
            valve_nx = 4'b0;
            if (bus.alarm_clr) begin
               state_nx = IDLE;
               alarm_nx = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase

      valve_nx = valve_nx | open_mask;
      for (int i = 0; i < 4; i++) begin
         if (open_mask[i]) on_nx[i] = '0;
      end

      lock_nx = (lockout & req) | forced;

      if (fault_in) begin
         state_nx = FAULT;
         valve_nx = 4'b0;
         alarm_nx = 1'b1;
         lead_nx  = '0;
         stag_nx  = '0;
         lock_nx  = 4'b0;
         for (int i = 0; i < 4; i++) on_nx[i] = '0;
      end

      active_nx = (state_nx == PUMP_START) || (state_nx == RUN);
   end

   // State, actuator outputs and timers, all registered with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         valve_q  <= 4'b0;
         pump_q   <= 1'b0;
         alarm_q  <= 1'b0;
         busy_q   <= 1'b0;
         lead_cnt <= '0;
         stag_cnt <= '0;
         lockout  <= 4'b0;
         for (int i = 0; i < 4; i++) on_cnt[i] <= '0;
      end else begin
         state    <= state_nx;
         valve_q  <= valve_nx;
         pump_q   <= active_nx;
         alarm_q  <= alarm_nx;
         busy_q   <= active_nx;
         lead_cnt <= lead_nx;
         stag_cnt <= stag_nx;
         lockout  <= lock_nx;
         for (int i = 0; i < 4; i++) on_cnt[i] <= on_nx[i];
      end
   end

endmodule

// File: tb/tb_valve_sequencer.sv
// tb/tb_valve_sequencer.sv - randomized and directed checks of valve_sequencer against a timestamp model
module tb_valve_sequencer;

   localparam int PUMP_LEAD = 4;
   localparam int STAGGER   = 3;
   localparam int MIN_ON    = 8;
   localparam int MAX_ON    = 64;

   localparam int M_IDLE  = 0;
   localparam int M_LEAD  = 1;
   localparam int M_RUN   = 2;
   localparam int M_FAULT = 3;

   logic clk;
   logic reset;
   valve_sequencer_if bus ();

   valve_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: absolute edge timestamps instead of counters.
   int       m_mode;
   int       m_edge;
   int       m_lead_start;
   int       m_last_open;
   int       m_opened_at [4];
   bit [3:0] m_valve;
   bit [3:0] m_lock;
   bit       m_alarm;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_edge  = 0;
      m_valve = 4'b0;
      m_lock  = 4'b0;
      m_alarm = 1'b0;
   endtask

   task automatic model_open_lowest(input bit [3:0] mask, inout bit [3:0] nv);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!done && mask[i]) begin
            done           = 1'b1;
            nv[i]          = 1'b1;
            m_opened_at[i] = m_edge;
            m_last_open    = m_edge;
         end
      end
   endtask

   task automatic model_step();
      bit [3:0] req, eff, nv, forced;
      int held;
      req    = {bus.r2, bus.r1};
      eff    = req & ~m_lock;
      nv     = m_valve;
      forced = 4'b0;
      if (bus.e == 2'b00) begin
         m_mode  = M_FAULT;
         nv      = 4'b0;
         m_alarm = 1'b1;
         m_lock  = 4'b0;
      end else begin
         case (m_mode)
            M_IDLE: if (eff != 4'b0) begin
               m_mode       = M_LEAD;
               m_lead_start = m_edge;
            end
            M_LEAD: begin
               if (eff == 4'b0) m_mode = M_IDLE;
               else if (m_edge - m_lead_start >= PUMP_LEAD) begin
                  m_mode = M_RUN;
                  model_open_lowest(eff, nv);
               end
            end
            M_RUN: begin
               for (int i = 0; i < 4; i++) begin
                  if (m_valve[i]) begin
                     held = m_edge - m_opened_at[i];
                     if (held >= MAX_ON) begin
                        nv[i]     = 1'b0;
                        forced[i] = 1'b1;
                     end else if (!req[i] && held >= MIN_ON) begin
                        nv[i] = 1'b0;
                     end
                  end
               end
               if (m_edge - m_last_open >= STAGGER) model_open_lowest(eff & ~m_valve, nv);
               if (nv == 4'b0 && eff == 4'b0) m_mode = M_IDLE;
            end
            default: if (bus.alarm_clr) begin
               m_mode  = M_IDLE;
               m_alarm = 1'b0;
            end
         endcase
         m_lock = (m_lock & req) | forced;
      end
      m_valve = nv;
      m_edge++;
   endtask

   task automatic check_outputs();
      bit active;
      active = (m_mode == M_LEAD) || (m_mode == M_RUN);
      chk("valve", int'(bus.valve), int'(m_valve));
      chk("pump",  int'(bus.pump),  int'(active));
      chk("busy",  int'(bus.busy),  int'(active));
      chk("alarm", int'(bus.alarm), int'(m_alarm));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset         = 1'b1;
      bus.r1        = 2'b00;
      bus.r2        = 2'b00;
      bus.e         = 2'b01;
      bus.alarm_clr = 1'b0;
      @(negedge clk);
      model_reset();
      check_outputs();
      reset = 1'b0;
   endtask

   initial begin
      int cnt;
      bit closed;
      bit [3:0] prev;
      int rise_at [4];

      reset         = 1'b1;
      bus.r1        = 2'b00;
      bus.r2        = 2'b00;
      bus.e         = 2'b01;
      bus.alarm_clr = 1'b0;
      model_reset();

      // Single outlet: lead time, then release before MIN_ON.
      do_reset();
      bus.r1 = 2'b01;
      cycle();
      chk("s1_pump_edge0", int'(bus.pump), 1);
      for (int k = 1; k < 4; k++) cycle();
      chk("s1_valve_before_lead", int'(bus.valve), 0);
      cycle();
      chk("s1_valve_edge4", int'(bus.valve), 1);
      cnt = 1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         cnt += int'(bus.valve[0]);
         chk("s1_busy_held", int'(bus.busy), 1);
      end
      bus.r1 = 2'b00;
      closed = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (!closed) begin
            cycle();
            if (bus.valve[0]) cnt++;
            else begin
               closed = 1'b1;
               chk("s1_pump_at_close", int'(bus.pump), 0);
            end
         end
      end
      chk("s1_closed", int'(closed), 1);
      chk("s1_open_cycles", cnt, MIN_ON);

      // Three outlets together: staggered openings.
      do_reset();
      bus.r1 = 2'b11;
      bus.r2 = 2'b01;
      prev = 4'b0;
      for (int i = 0; i < 4; i++) rise_at[i] = -1;
      for (int k = 0; k < 16; k++) begin
         cycle();
         for (int i = 0; i < 4; i++) begin
            if (bus.valve[i] && !prev[i] && rise_at[i] < 0) rise_at[i] = k;
         end
         prev = bus.valve;
      end
      chk("s2_rise_bit0", rise_at[0], 4);
      chk("s2_rise_bit1", rise_at[1], 7);
      chk("s2_rise_bit2", rise_at[2], 10);
      chk("s2_rise_bit3", rise_at[3], -1);

      // Held request: MAX_ON force-close, lockout, then re-raise restarts the lead.
      do_reset();
      bus.r1 = 2'b01;
      for (int k = 0; k < 5; k++) cycle();
      cnt = 1;
      closed = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (!closed) begin
            cycle();
            if (bus.valve[0]) cnt++;
            else closed = 1'b1;
         end
      end
      chk("s3_forced_close", int'(closed), 1);
      chk("s3_open_cycles", cnt, MAX_ON);
      for (int k = 0; k < 10; k++) cycle();
      chk("s3_locked_valve", int'(bus.valve), 0);
      chk("s3_locked_pump", int'(bus.pump), 0);
      bus.r1 = 2'b00;
      cycle();
      bus.r1 = 2'b01;
      rise_at[0] = -1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (bus.valve[0] && rise_at[0] < 0) rise_at[0] = k;
      end
      chk("s3_reopen_edge", rise_at[0], 4);

      // Fault latch with two valves open, ignored and accepted acknowledge.
      do_reset();
      bus.r1 = 2'b11;
      for (int k = 0; k < 8; k++) cycle();
      chk("s4_two_open", int'(bus.valve), 3);
      bus.e = 2'b00;
      cycle();
      chk("s4_fault_valve", int'(bus.valve), 0);
      chk("s4_fault_pump", int'(bus.pump), 0);
      chk("s4_fault_alarm", int'(bus.alarm), 1);
      bus.alarm_clr = 1'b1;
      cycle();
      chk("s4_clr_ignored", int'(bus.alarm), 1);
      bus.e = 2'b01;
      cycle();
      chk("s4_clr_alarm", int'(bus.alarm), 0);
      chk("s4_clr_busy", int'(bus.busy), 0);
      bus.alarm_clr = 1'b0;
      for (int k = 0; k < 6; k++) cycle();

      // Asynchronous reset in RUN, then a full lead sequence again.
      do_reset();
      bus.r1 = 2'b11;
      for (int k = 0; k < 12; k++) cycle();
      #2;
      reset = 1'b1;
      #1;
      chk("s5_async_valve", int'(bus.valve), 0);
      chk("s5_async_pump", int'(bus.pump), 0);
      chk("s5_async_busy", int'(bus.busy), 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      model_reset();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) cycle();
      chk("s5_no_early_open", int'(bus.valve), 0);
      cycle();
      chk("s5_reopen", int'(bus.valve), 1);

      // Random traffic: fast-changing requests, then slow ones that reach MAX_ON.
      for (int phase = 0; phase < 2; phase++) begin
         for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, (phase == 0) ? 29 : 119) == 0) bus.r1 = 2'($urandom);
            if ($urandom_range(0, (phase == 0) ? 29 : 119) == 0) bus.r2 = 2'($urandom);
            if ($urandom_range(0, 249) == 0) bus.e = 2'b00;
            else if (bus.e == 2'b00 && $urandom_range(0, 3) == 0) bus.e = 2'($urandom_range(1, 3));
            bus.alarm_clr = ($urandom_range(0, 3) == 0);
            cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
